map_sched: RTL and testbench

//  Round-robin scheduler sharing one 8x8 circle-map generator (Map) among NREQ requesters.

---
 rtl/map_sched.sv | 196 +++++++++++++++++++
 tb/tb_map_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_sched.sv
`default_nettype none
// ============================================================================
//  Module      : map_sched
//  Description : Round-robin scheduler that shares one 8x8 circle-map engine
//                among NREQ requesters. Range-checks {x,y,r}, pulses the
//                engine reset, waits for done (with timeout) and returns the
//                map tagged with the requester id.
//                Optional OR-accumulator of good maps: MAP_SCHED_ACCUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module map_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [12*NREQ-1:0] req_xyr,
    output logic [NREQ-1:0]    req_grant,
    output logic [3:0]         map_x,
    output logic [3:0]         map_y,
    output logic [3:0]         map_r,
    output logic               map_reset,
    input  logic               map_done,
    input  logic [63:0]        map_data,
    output logic               resp_valid,
    output logic [2:0]         resp_id,
    output logic [63:0]        resp_map,
    output logic               resp_err,
`ifdef MAP_SCHED_ACCUM_EN
    input  logic               acc_clr,
    output logic [63:0]        acc_map,
`endif
    output logic               busy
);

    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_id;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_map_rst;

    logic               w_found;
    logic [2:0]         w_win;
    logic [11:0]        w_xyr;
    logic               w_in_range;

    // Winner search: first pending requester after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] && ((int'(r_ptr) + k) % NREQ) == i) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                end
            end
        end
    end

    // Operand mux for the winner and its range check (x,y must be 1..8)
    always_comb begin
        w_xyr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 3'(i)) begin
                w_xyr = req_xyr[12*i +: 12];
            end
        end
        w_in_range = (w_xyr[11:8] >= 4'd1) && (w_xyr[11:8] <= 4'd8) &&
                     (w_xyr[7:4]  >= 4'd1) && (w_xyr[7:4]  <= 4'd8);
    end

    // Grant is decoded in ARB from the live request so the handshake lands in
    // the same cycle the operands are captured
    always_comb begin
        req_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_state == S_ARB && w_found && w_win == 3'(i)) begin
                req_grant[i] = 1'b1;
            end
        end
    end

    // The engine stays in reset for as long as the scheduler does
    assign map_reset = r_map_rst | ~reset_n;

    // Main scheduler FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 3'(NREQ - 1);
            r_id       <= '0;
            r_cnt      <= '0;
            r_map_rst  <= 1'b0;
            map_x      <= '0;
            map_y      <= '0;
            map_r      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_map   <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            r_map_rst  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_state <= S_ARB;
                        busy    <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        r_ptr <= w_win;
                        r_id  <= w_win;
                        map_x <= w_xyr[11:8];
                        map_y <= w_xyr[7:4];
                        map_r <= w_xyr[3:0];
                        if (w_in_range) begin
                            r_state   <= S_LOAD;
                            r_map_rst <= 1'b1;
                        end else begin
                            // Bad operands: answer at once, engine untouched
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_id    <= w_win;
                            resp_map   <= '0;
                            resp_err   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // map_done is not looked at here: it may still be the
                    // previous run's result
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    if (map_done) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= r_id;
                        resp_map   <= map_data;
                        resp_err   <= 1'b0;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= r_id;
                        resp_map   <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAP_SCHED_ACCUM_EN
    // OR together every good map; a clear wins over a same-cycle update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_map <= '0;
        end else if (acc_clr) begin
            acc_map <= '0;
        end else if (r_state == S_RESP && !resp_err) begin
            acc_map <= acc_map | resp_map;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_map_sched
//  Description : Directed self-checking bench for map_sched with a stub Map
//                engine. Accumulator steps compile in with MAP_SCHED_ACCUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_map_sched;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [23:0] req_xyr;
    logic [1:0]  req_grant;
    logic [3:0]  map_x, map_y, map_r;
    logic        map_reset;
    logic        map_done;
    logic [63:0] map_data;
    logic        resp_valid;
    logic [2:0]  resp_id;
    logic [63:0] resp_map;
    logic        resp_err;
    logic        busy;
`ifdef MAP_SCHED_ACCUM_EN
    logic        acc_clr;
    logic [63:0] acc_map;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mr_cnt = 0;
    int resp_cnt = 0;

    map_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_xyr    (req_xyr),
        .req_grant  (req_grant),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_r      (map_r),
        .map_reset  (map_reset),
        .map_done   (map_done),
        .map_data   (map_data),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_map   (resp_map),
        .resp_err   (resp_err),
`ifdef MAP_SCHED_ACCUM_EN
        .acc_clr    (acc_clr),
        .acc_map    (acc_map),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference circle map: bit j*8+i set when (i,j) lies within r of (x-1,y-1)
    function automatic logic [63:0] circle(input logic [3:0] x, input logic [3:0] y,
                                           input logic [3:0] r);
        logic [63:0] m;
        int dx, dy;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                dx = i - (int'(x) - 1);
                dy = j - (int'(y) - 1);
                if (dx*dx + dy*dy <= int'(r)*int'(r)) m[j*8+i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Stub Map: done rises in the (x+y)-th cycle after map_reset drops and
    // stays up (a stale done is visible during the next LOAD)
    logic [7:0] m_cnt;
    logic       stub_dead = 1'b0;
    always @(posedge clk) begin
        if (map_reset) m_cnt <= 8'd0;
        else if (m_cnt != 8'hff) m_cnt <= m_cnt + 8'd1;
    end
    assign map_done = !stub_dead && ((m_cnt + 8'd1) >= (8'(map_x) + 8'(map_y)));
    assign map_data = circle(map_x, map_y, map_r);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && map_reset) mr_cnt <= mr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output logic [1:0] g, output int gc);
        g  = '0;
        gc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_grant != '0) begin
                g  = req_grant;
                gc = cyc;
                return;
            end
        end
        total++; bad++;
        $error("FAIL grant_wait observed=none expected=grant");
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc = cyc;
                return;
            end
        end
        total++; bad++;
        $error("FAIL resp_wait observed=none expected=resp_valid");
    endtask

    // One request from requester i, dropped right after its grant
    task automatic run_one(input int i, input logic [3:0] x, input logic [3:0] y,
                           input logic [3:0] r, output logic [1:0] g,
                           output int gc, output int rc);
        req_xyr[12*i +: 12] = {x, y, r};
        req_valid[i] = 1'b1;
        wait_grant(g, gc);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(rc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        int gc, rc, mr0, rc0;
        logic [1:0] exp_g [4];
        logic [11:0] slot [2];

        reset_n   = 1'b0;
        req_valid = '0;
        req_xyr   = '0;
`ifdef MAP_SCHED_ACCUM_EN
        acc_clr   = 1'b0;
`endif
        // ---- reset state
        repeat (2) @(negedge clk);
        check("rst_grant", req_grant, 2'b00);
        check("rst_map_reset", map_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_map_x", map_x, 4'd0);
        check("rst_resp_map", resp_map, 64'd0);
`ifdef MAP_SCHED_ACCUM_EN
        check("rst_acc", acc_map, 64'd0);
`endif
        #2 reset_n = 1'b1;
        #1 check("rel_map_reset", map_reset, 1'b0);
        @(negedge clk);

        // ---- 1: single centre dot, latency 4
        mr0 = mr_cnt;
        run_one(0, 4'd1, 4'd1, 4'd0, g, gc, rc);
        check("t1_grant", g, 2'b01);
        check("t1_latency", rc - gc, 4);
        check("t1_id", resp_id, 3'd0);
        check("t1_err", resp_err, 1'b0);
        check("t1_map", resp_map, 64'h0000_0000_0000_0001);
        check("t1_busy_resp", busy, 1'b1);
        @(negedge clk);
        check("t1_busy_after", busy, 1'b0);
        check("t1_valid_after", resp_valid, 1'b0);
        check("t1_id_hold", resp_id, 3'd0);
        check("t1_map_x_hold", map_x, 4'd1);
        check("t1_mr_pulses", mr_cnt - mr0, 1);

        // ---- 2: both requesting continuously; pointer is at 0, so 1 goes first
        slot[0] = {4'd2, 4'd3, 4'd1};
        slot[1] = {4'd4, 4'd2, 4'd2};
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        req_xyr   = {slot[1], slot[0]};
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            int w;
            wait_grant(g, gc);
            check("t2_grant", g, exp_g[n]);
            w = (exp_g[n] == 2'b01) ? 0 : 1;
            wait_resp(rc);
            check("t2_id", resp_id, 3'(w));
            check("t2_err", resp_err, 1'b0);
            check("t2_map", resp_map, circle(slot[w][11:8], slot[w][7:4], slot[w][3:0]));
            check("t2_latency", rc - gc, 2 + int'(slot[w][11:8]) + int'(slot[w][7:4]));
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        // ---- 3: x=0 is out of range: immediate error, no engine reset
        mr0 = mr_cnt;
        run_one(1, 4'd0, 4'd5, 4'd2, g, gc, rc);
        check("t3_grant", g, 2'b10);
        check("t3_latency", rc - gc, 1);
        check("t3_id", resp_id, 3'd1);
        check("t3_err", resp_err, 1'b1);
        check("t3_map", resp_map, 64'd0);
        @(negedge clk);
        check("t3_mr_pulses", mr_cnt - mr0, 0);

        // ---- 4: engine never finishes: ARB, LOAD, TIMEOUT RUN cycles, RESP
        stub_dead = 1'b1;
        run_one(0, 4'd3, 4'd3, 4'd1, g, gc, rc);
        check("t4_grant", g, 2'b01);
        check("t4_latency", rc - gc, TIMEOUT + 2);
        check("t4_err", resp_err, 1'b1);
        check("t4_map", resp_map, 64'd0);
        check("t4_busy_resp", busy, 1'b1);
        @(negedge clk);
        check("t4_busy_after", busy, 1'b0);
        stub_dead = 1'b0;

        // ---- 5: reset in the middle of a long run (pointer now at 0)
        req_xyr[11:0] = {4'd8, 4'd8, 4'd3};
        req_valid = 2'b01;
        wait_grant(g, gc);
        check("t5_grant", g, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
        rc0 = resp_cnt;
        reset_n = 1'b0;
        #1;
        check("t5_map_reset", map_reset, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_resp_valid", resp_valid, 1'b0);
        check("t5_map_x", map_x, 4'd0);
        check("t5_resp_map", resp_map, 64'd0);
        repeat (3) @(negedge clk);
        check("t5_map_reset_hold", map_reset, 1'b1);
        #2 reset_n = 1'b1;
        @(negedge clk);
        req_xyr   = {4'd2, 4'd2, 4'd0, 4'd1, 4'd1, 4'd0};
        req_valid = 2'b11;
        wait_grant(g, gc);
        check("t5_restart_grant", g, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(rc);
        check("t5_id", resp_id, 3'd0);
        check("t5_no_resp_in_reset", resp_cnt - rc0, 0);
        @(negedge clk);

`ifdef MAP_SCHED_ACCUM_EN
        // ---- 6: accumulator
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        @(negedge clk);
        check("t6_clr0", acc_map, 64'd0);
        run_one(1, 4'd3, 4'd3, 4'd1, g, gc, rc);
        run_one(0, 4'd6, 4'd6, 4'd2, g, gc, rc);
        @(negedge clk);
        check("t6_or", acc_map, circle(4'd3, 4'd3, 4'd1) | circle(4'd6, 4'd6, 4'd2));
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        @(negedge clk);
        check("t6_clr1", acc_map, 64'd0);
        acc_clr = 1'b1;
        run_one(1, 4'd4, 4'd4, 4'd1, g, gc, rc);
        @(negedge clk);
        check("t6_clr_in_resp", acc_map, 64'd0);
        acc_clr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
